// File: rtl/kyber_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : kyber_ctrl_pkg
// Brief    : Shared state encoding and status-byte bit positions for the
//            Kyber operation control/status block.
// Revision : 1.0 - initial release
// =============================================================================
package kyber_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } op_state_e;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TMO     = 2;
    localparam int ST_OVR     = 3;
    localparam int ST_CNT_LSB = 4;

endpackage : kyber_ctrl_pkg
`default_nettype wire

// File: rtl/op_cycle_counter.sv
`default_nettype none
// =============================================================================
// Module   : op_cycle_counter
// Brief    : Loadable, saturating latency counter with a compare against the
//            timeout limit.
// Revision : 1.0 - initial release
// =============================================================================
module op_cycle_counter
    import kyber_ctrl_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] c_max   = '1;
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Load starts at 1: the first WAIT cycle already counts as one cycle of latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_one;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count    = r_count;
    assign at_limit = (r_count == c_limit);

endmodule : op_cycle_counter
`default_nettype wire

// File: rtl/op_status_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : op_status_ctrl
// Brief    : Launches the Kyber core on start_pulse, measures latency, flags
//            timeout/overrun and reports status to software.
// Revision : 1.0 - initial release
// =============================================================================
module op_status_ctrl
    import kyber_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic             status_clr,
    input  logic             core_done,
    output logic             core_start,
    output logic [7:0]       status_out,
    output logic [CNT_W-1:0] cycles_out
);

    op_state_e        r_state;
    op_state_e        w_state_nxt;
    logic             w_launch;
    logic             w_ovr_evt;
    logic             w_done_evt;
    logic             w_tmo_evt;
    logic             w_cnt_load;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_count;
    logic             w_at_limit;

    logic             r_core_start;
    logic             r_busy;
    logic             r_done;
    logic             r_tmo;
    logic             r_ovr;
    logic [3:0]       r_op_count;
    logic [CNT_W-1:0] r_cycles;

    op_cycle_counter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .inc      (w_cnt_inc),
        .count    (w_count),
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion is tested before the limit so a core_done in the timeout cycle wins.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_ovr_evt   = 1'b0;
        w_done_evt  = 1'b0;
        w_tmo_evt   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_pulse) begin
                    w_launch    = 1'b1;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_ovr_evt   = start_pulse;
                w_cnt_load  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_ovr_evt = start_pulse;
                if (core_done) begin
                    w_done_evt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_at_limit) begin
                    w_tmo_evt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sticky bits: clear first, then any set event at the same edge overrides.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tmo        <= 1'b0;
            r_ovr        <= 1'b0;
            r_op_count   <= '0;
            r_cycles     <= '0;
        end else begin
            r_core_start <= w_launch;
            if (status_clr) begin
                r_done <= 1'b0;
                r_tmo  <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (w_launch) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_tmo  <= 1'b0;
            end
            if (w_ovr_evt) begin
                r_ovr <= 1'b1;
            end
            if (w_done_evt) begin
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_op_count <= r_op_count + 4'd1;
                r_cycles   <= w_count;
            end
            if (w_tmo_evt) begin
                r_busy   <= 1'b0;
                r_tmo    <= 1'b1;
                r_cycles <= w_count;
            end
        end
    end

    always_comb begin
        status_out                      = '0;
        status_out[ST_BUSY]             = r_busy;
        status_out[ST_DONE]             = r_done;
        status_out[ST_TMO]              = r_tmo;
        status_out[ST_OVR]              = r_ovr;
        status_out[ST_CNT_LSB +: 4]     = r_op_count;
    end

    assign core_start = r_core_start;
    assign cycles_out = r_cycles;

endmodule : op_status_ctrl
`default_nettype wire
